mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: width of word addresses.
REQ-003 SHALL have parameter BLOCK_SIZE, default 4: words per read burst (power of 2).
REQ-004 SHALL have parameter TIMEOUT, default 63: maximum cycles in WAIT before abort.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports p0_rd, p0_wr, input, 1 each: data-cache read-block / write-word request (level, held until p0_done).
REQ-008 SHALL have ports p0_addr, input, ADDR_WIDTH, and p0_wdata, input, DATA_WIDTH: port 0 address and write data.
REQ-009 SHALL have port p1_rd, input, 1, and p1_addr, input, ADDR_WIDTH: instruction-cache read-block request (level) and its address.
REQ-010 SHALL have ports p0_gnt, p1_gnt, output, 1 each: one-cycle grant pulse.
REQ-011 SHALL have ports p0_rvalid, p1_rvalid, output, 1 each: burst word valid for that port.
REQ-012 SHALL have ports p0_done, p1_done, output, 1 each: one-cycle transaction-complete pulse.
REQ-013 SHALL have ports rdata, output, DATA_WIDTH, and rword, output, log2(BLOCK_SIZE): shared read data and its word index.
REQ-014 SHALL have ports err, output, 1 (pulse with done on timeout), and busy, output, 1 (state != IDLE).
REQ-015 SHALL have ports mem_rd_en, mem_wr_en, output, 1 each; mem_addr, output, ADDR_WIDTH; mem_wdata, output, DATA_WIDTH: memory command.
REQ-016 SHALL have ports mem_ready, mem_done, mem_rvalid, input, 1 each, and mem_rd_data, input, DATA_WIDTH: memory status and burst data.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, BURST, FINISH.
REQ-018 IDLE: SHALL leave only when mem_ready=1 and at least one request is pending; next state ISSUE.
REQ-019 Arbitration SHALL be round-robin: on conflict, grant the port not granted last; last_grant updates in FINISH.
REQ-020 Port 0 with p0_rd and p0_wr both high SHALL be served as a write; the read remains pending afterwards.
REQ-021 On IDLE->ISSUE SHALL latch port, op and address; reads latch address with low log2(BLOCK_SIZE) bits cleared; writes latch p0_wdata.
REQ-022 ISSUE (exactly 1 cycle): SHALL assert mem_rd_en or mem_wr_en, drive latched mem_addr/mem_wdata, pulse the winner's gnt; next WAIT.
REQ-023 mem_rd_en/mem_wr_en SHALL be 0 in every state except ISSUE.
REQ-024 WAIT: read -> BURST on first mem_rvalid=1 (word 0 is forwarded that cycle); write -> FINISH on mem_done=1.
REQ-025 WAIT SHALL count cycles; on count reaching TIMEOUT -> FINISH with err set; counter clears on leaving WAIT.
REQ-026 BURST: each cycle with mem_rvalid=1 SHALL forward mem_rd_data to rdata, present the word counter on rword, pulse the owner's rvalid, increment the counter.
REQ-027 mem_rvalid=0 in BURST SHALL stall (no rvalid, counter held).
REQ-028 After word BLOCK_SIZE-1 is forwarded SHALL go to FINISH; counter wraps to 0.
REQ-029 FINISH (1 cycle): SHALL pulse owner's done (and err if timed out) and return to IDLE.
REQ-030 Requests dropped before grant SHALL be ignored; requests dropped after grant SHALL NOT abort the transaction.
REQ-031 A new grant SHALL NOT occur earlier than the cycle after FINISH (minimum 1 IDLE cycle).
REQ-032 Non-owner rvalid/done/gnt SHALL stay 0 throughout a transaction.

Reset
REQ-033 reset SHALL force state IDLE, last_grant=1 (port 0 wins first tie), counters 0, all outputs 0, from any state, immediately.
REQ-034 After reset release, a transaction in progress before reset SHALL NOT complete or emit done.

Verification
REQ-035 p0_rd, p0_addr=0x13, memory returns 4 words after 20 cycles -> mem_addr=0x10, p0_rvalid x4 with rword 0..3, one p0_done.
REQ-036 p0_rd and p1_rd same cycle from reset -> port 0 served first, then port 1; repeat -> port 1 first.
REQ-037 p0_wr, p0_addr=0x20, p0_wdata=0xDEADBEEF, mem_done after 4 cycles -> one mem_wr_en pulse with those values, p0_done, no rvalid.
REQ-038 p1_rd, memory never responds -> p1_done and err together 63 cycles into WAIT, then IDLE.
REQ-039 p1 read with mem_rvalid gap after word 1 -> rvalid gap, rword continues at 2, 4 words total.
REQ-040 reset asserted in BURST after word 2 -> all outputs 0 immediately, no done; next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin between data-cache (read block / write word) and instruction-cache (read block) requests.
// Latency: grant 1 cycle after an accepted request; read words forwarded combinationally; done 1 cycle after last word, mem_done or timeout.
// Backpressure: requests are level-held until done; memory stalls are absorbed in WAIT (bounded by TIMEOUT) and BURST (unbounded).
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          p0_rd,
    input  logic                          p0_wr,
    input  logic [ADDR_WIDTH-1:0]         p0_addr,
    input  logic [DATA_WIDTH-1:0]         p0_wdata,
    input  logic                          p1_rd,
    input  logic [ADDR_WIDTH-1:0]         p1_addr,
    output logic                          p0_gnt,
    output logic                          p1_gnt,
    output logic                          p0_rvalid,
    output logic                          p1_rvalid,
    output logic                          p0_done,
    output logic                          p1_done,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [$clog2(BLOCK_SIZE)-1:0] rword,
    output logic                          err,
    output logic                          busy,
    output logic                          mem_rd_en,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_ready,
    input  logic                          mem_done,
    input  logic                          mem_rvalid,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data
);
    localparam int WORD_W = $clog2(BLOCK_SIZE);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [WORD_W-1:0]     WORD_LAST = WORD_W'(BLOCK_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BURST, FINISH} state_t;

    state_t                state, state_nxt;
    logic                  owner;       // 0 = port 0, 1 = port 1
    logic                  op_wr;
    logic                  last_grant;
    logic                  timed_out;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [WORD_W-1:0]     word_cnt;
    logic [CNT_W-1:0]      wait_cnt;

    logic p0_req, p1_req, pick_p1, start, beat, last_beat, wait_hit, wait_expire;

    assign p0_req    = p0_rd | p0_wr;
    assign p1_req    = p1_rd;
    // On a tie the port that did not win last time goes first.
    assign pick_p1   = (p0_req && p1_req) ? ~last_grant : p1_req;
    assign start     = (state == IDLE) && mem_ready && (p0_req || p1_req);
    assign beat      = ((state == WAIT) || (state == BURST)) && !op_wr && mem_rvalid;
    assign last_beat = beat && (word_cnt == WORD_LAST);
    assign wait_hit  = op_wr ? mem_done : mem_rvalid;
    assign wait_expire = (state == WAIT) && !wait_hit && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (wait_hit)
                    state_nxt = (op_wr || last_beat) ? FINISH : BURST;
                else if (wait_expire)
                    state_nxt = FINISH;
            end
            BURST:   if (last_beat) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        err       = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ISSUE) begin
            p0_gnt    = ~owner;
            p1_gnt    = owner;
            mem_rd_en = ~op_wr;
            mem_wr_en = op_wr;
            mem_addr  = addr_q;
            mem_wdata = op_wr ? wdata_q : '0;
        end
        if (state == FINISH) begin
            p0_done = ~owner;
            p1_done = owner;
            err     = timed_out;
        end
    end

    assign p0_rvalid = beat & ~owner;
    assign p1_rvalid = beat & owner;
    assign rdata     = beat ? mem_rd_data : '0;
    assign rword     = beat ? word_cnt : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            op_wr      <= 1'b0;
            last_grant <= 1'b1;
            timed_out  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_cnt   <= '0;
            wait_cnt   <= '0;
        end else begin
            if (start) begin
                owner     <= pick_p1;
                op_wr     <= !pick_p1 && p0_wr;
                timed_out <= 1'b0;
                wdata_q   <= p0_wdata;
                // Writes address a single word; reads fetch the whole aligned block.
                if (pick_p1)
                    addr_q <= p1_addr & BLK_MASK;
                else if (p0_wr)
                    addr_q <= p0_addr;
                else
                    addr_q <= p0_addr & BLK_MASK;
            end
            if (wait_expire)
                timed_out <= 1'b1;
            if (beat)
                word_cnt <= word_cnt + WORD_W'(1);
            if ((state == WAIT) && (state_nxt == WAIT))
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            if (state == FINISH)
                last_grant <= owner;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand sequences for arbitration, resets and stalls.
// A behavioural memory answers commands; expected commands, words and dones are queued and popped as the DUT emits them.
module tb_mem_arbiter;
    localparam int TO = 63;
    localparam int BS = 4;

    logic        clk, reset;
    logic        p0_rd, p0_wr, p1_rd;
    logic [31:0] p0_addr, p0_wdata, p1_addr;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_done, p1_done;
    logic [31:0] rdata;
    logic [1:0]  rword;
    logic        err, busy, mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_done, mem_rvalid;
    logic [31:0] mem_rd_data;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_SIZE(BS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_rd(p1_rd), .p1_addr(p1_addr),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_done(p0_done), .p1_done(p1_done), .rdata(rdata), .rword(rword),
        .err(err), .busy(busy), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_done(mem_done), .mem_rvalid(mem_rvalid), .mem_rd_data(mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { bit port; bit wr; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    typedef struct { bit port; logic [1:0] word; logic [31:0] data; } rd_t;
    typedef struct { bit port; bit wr; bit to; } done_t;
    typedef struct {
        bit port; bit wr; logic [31:0] addr; logic [31:0] wdata;
        int lat; int gap; bit silent;
        logic [31:0] exp_addr; bit exp_err;
    } vec_t;

    cmd_t  exp_cmd[$];
    rd_t   exp_rd[$];
    done_t exp_done[$];
    vec_t  vecs[7];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int last_done_cyc = 0;
    bit have_done = 0;

    // memory model state and configuration
    int          cfg_lat = 1;
    int          cfg_gap = -1;
    bit          cfg_silent = 0;
    bit          m_busy = 0, m_wr = 0, m_gap = 0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0, m_word = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int i);
        return {a[23:0], 8'(i)} ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_txn(input bit port, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit silent);
        exp_cmd.push_back('{port, wr, addr, wdata});
        if (!wr && !silent)
            for (int i = 0; i < BS; i++)
                exp_rd.push_back('{port, 2'(i), mem_word(addr, i)});
        exp_done.push_back('{port, wr, silent});
    endtask

    task automatic monitor();
        cmd_t c; rd_t r; done_t d;
        if (mem_rd_en || mem_wr_en) begin
            if (exp_cmd.size() == 0) chk("cmd_expected", {mem_rd_en, mem_wr_en}, 2'b00);
            else begin
                c = exp_cmd.pop_front();
                chk("cmd_op", {mem_wr_en, mem_rd_en}, c.wr ? 2'b10 : 2'b01);
                chk("cmd_addr", mem_addr, c.addr);
                if (c.wr) chk("cmd_wdata", mem_wdata, c.wdata);
                chk("gnt", {p1_gnt, p0_gnt}, c.port ? 2'b10 : 2'b01);
                if (have_done) chk("idle_gap", (cyc - last_done_cyc) >= 2, 1'b1);
                m_busy = 1; m_wr = mem_wr_en; m_addr = mem_addr;
                m_cnt = cfg_lat; m_word = 0; m_gap = 0; issue_cyc = cyc;
            end
        end else if (p0_gnt || p1_gnt) begin
            chk("gnt_without_cmd", {p1_gnt, p0_gnt}, 2'b00);
        end
        if (p0_rvalid || p1_rvalid) begin
            if (exp_rd.size() == 0) chk("rvalid_expected", {p1_rvalid, p0_rvalid}, 2'b00);
            else begin
                r = exp_rd.pop_front();
                chk("rvalid_port", {p1_rvalid, p0_rvalid}, r.port ? 2'b10 : 2'b01);
                chk("rword", rword, r.word);
                chk("rdata", rdata, r.data);
            end
        end
        if (err && !(p0_done || p1_done)) chk("err_without_done", err, 1'b0);
        if (p0_done || p1_done) begin
            if (exp_done.size() == 0) chk("done_expected", {p1_done, p0_done}, 2'b00);
            else begin
                d = exp_done.pop_front();
                chk("done_port", {p1_done, p0_done}, d.port ? 2'b10 : 2'b01);
                chk("err", err, d.to);
                if (d.to) chk("timeout_cycles", cyc - issue_cyc, TO + 1);
                if (d.port) p1_rd = 0;
                else if (d.wr) p0_wr = 0;
                else p0_rd = 0;
            end
            last_done_cyc = cyc; have_done = 1; m_busy = 0;
        end
    endtask

    // One clock: drive memory at the falling edge, then sample and check the DUT.
    task automatic tick();
        @(negedge clk);
        cyc++;
        mem_rvalid = 0; mem_done = 0; mem_rd_data = '0;
        if (reset) m_busy = 0;
        else if (m_busy) begin
            if (m_cnt > 1) m_cnt--;
            else if (m_wr) begin mem_done = 1; m_busy = 0; end
            else if (!cfg_silent) begin
                if (m_gap) m_gap = 0;
                else begin
                    mem_rvalid = 1; mem_rd_data = mem_word(m_addr, m_word);
                    if (m_word == cfg_gap) m_gap = 1;
                    m_word++;
                    if (m_word == BS) m_busy = 0;
                end
            end
        end
        #2;
        if (!reset) monitor();
    endtask

    task automatic wait_all(input int budget);
        int n = 0;
        while ((exp_cmd.size() + exp_rd.size() + exp_done.size()) != 0 && n < budget) begin
            tick(); n++;
        end
        if (n >= budget) begin
            chk("wait_budget", exp_cmd.size() + exp_rd.size() + exp_done.size(), 0);
            exp_cmd.delete(); exp_rd.delete(); exp_done.delete();
            p0_rd = 0; p0_wr = 0; p1_rd = 0;
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_done, p1_done,
                             err, busy, mem_rd_en, mem_wr_en}, 10'b0);
        chk({name, "_dat"}, {rdata, rword, mem_addr, mem_wdata}, 98'b0);
    endtask

    task automatic run_vec(input vec_t v);
        cfg_lat = v.lat; cfg_gap = v.gap; cfg_silent = v.silent;
        push_txn(v.port, v.wr, v.exp_addr, v.wdata, v.silent);
        if (v.port) begin p1_rd = 1; p1_addr = v.addr; end
        else begin
            p0_addr = v.addr; p0_wdata = v.wdata;
            if (v.wr) p0_wr = 1; else p0_rd = 1;
        end
        wait_all(200);
        tick();
        chk("busy_after_txn", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        //        port wr  addr          wdata          lat gap silent exp_addr      err
        vecs[0] = '{0, 0, 32'h13,        32'h0,         20, -1, 0, 32'h10,        0};
        vecs[1] = '{0, 1, 32'h20,        32'hDEADBEEF,  4,  -1, 0, 32'h20,        0};
        vecs[2] = '{1, 0, 32'h47,        32'h0,         3,   1, 0, 32'h44,        0};
        vecs[3] = '{1, 0, 32'h100,       32'h0,         1,  -1, 1, 32'h100,       1};
        vecs[4] = '{1, 0, 32'h8,         32'h0,         2,   0, 0, 32'h8,         0};
        vecs[5] = '{0, 0, 32'hFFFFFFFF,  32'h0,         1,  -1, 0, 32'hFFFFFFFC,  0};
        vecs[6] = '{0, 1, 32'h7,         32'h12345678,  1,  -1, 0, 32'h7,         0};

        reset = 1; p0_rd = 0; p0_wr = 0; p1_rd = 0;
        p0_addr = '0; p0_wdata = '0; p1_addr = '0;
        mem_ready = 1; mem_done = 0; mem_rvalid = 0; mem_rd_data = '0;
        repeat (3) tick();
        check_zero("reset");
        reset = 0;
        tick();

        // Tie straight out of reset: port 0 first, then the held port 1 request.
        cfg_lat = 3; cfg_gap = -1; cfg_silent = 0;
        push_txn(0, 0, 32'h40, 32'h0, 0);
        push_txn(1, 0, 32'h80, 32'h0, 0);
        p0_rd = 1; p0_addr = 32'h40; p1_rd = 1; p1_addr = 32'h80;
        wait_all(100);
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Port 0 was granted last, so the next tie goes to port 1 first.
        cfg_lat = 2; cfg_gap = -1; cfg_silent = 0;
        push_txn(1, 0, 32'hC0, 32'h0, 0);
        push_txn(0, 0, 32'hE0, 32'h0, 0);
        p0_rd = 1; p0_addr = 32'hE3; p1_rd = 1; p1_addr = 32'hC1;
        wait_all(100);
        tick();

        // Read and write together: write first, read stays pending and follows.
        push_txn(0, 1, 32'h55, 32'hCAFEF00D, 0);
        push_txn(0, 0, 32'h54, 32'h0, 0);
        p0_addr = 32'h55; p0_wdata = 32'hCAFEF00D; p0_rd = 1; p0_wr = 1;
        wait_all(100);
        tick();

        // A port 1 request raised and dropped while port 0 owns memory is ignored.
        cfg_lat = 10;
        push_txn(0, 0, 32'h60, 32'h0, 0);
        p0_rd = 1; p0_addr = 32'h60;
        repeat (3) tick();
        p1_rd = 1; p1_addr = 32'h90;
        repeat (3) tick();
        p1_rd = 0;
        wait_all(100);
        repeat (4) tick();
        chk("drop_before_gnt_idle", busy, 1'b0);

        // Dropping the request after grant still completes the transaction.
        cfg_lat = 5;
        push_txn(1, 0, 32'h200, 32'h0, 0);
        p1_rd = 1; p1_addr = 32'h200;
        n = 0;
        do begin tick(); n++; end while (!p1_gnt && n < 10);
        chk("gnt_seen", p1_gnt, 1'b1);
        p1_rd = 0;
        wait_all(100);
        tick();

        // mem_ready low holds the arbiter in IDLE.
        mem_ready = 0; cfg_lat = 1;
        p1_rd = 1; p1_addr = 32'h0C;
        repeat (5) tick();
        chk("ready_block_busy", busy, 1'b0);
        push_txn(1, 0, 32'h0C, 32'h0, 0);
        mem_ready = 1;
        wait_all(100);
        tick();

        // Reset in BURST after word 2: outputs clear at once and the old transfer never completes.
        cfg_lat = 2;
        push_txn(0, 0, 32'h300, 32'h0, 0);
        p0_rd = 1; p0_addr = 32'h300;
        n = 0;
        while (exp_rd.size() != 1 && n < 40) begin tick(); n++; end
        chk("reached_word2", exp_rd.size(), 1);
        reset = 1;
        #1;
        check_zero("midburst_reset");
        p0_rd = 0;
        exp_cmd.delete(); exp_rd.delete(); exp_done.delete();
        repeat (2) tick();
        reset = 0;
        repeat (10) tick();
        chk("post_reset_idle", busy, 1'b0);
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
